// File: rtl/cache_pkg.sv
// cache_pkg: shared constants, field slices and FSM state type for the cache miss path.
// Contents: address field bounds, metadata geometry, fill FSM states, MRU LRU code.
package cache_pkg;
    localparam int TAG_HI = 15;
    localparam int TAG_LO = 9;
    localparam int IDX_HI = 8;
    localparam int IDX_LO = 4;
    localparam int OFF_HI = 3;
    localparam int OFF_LO = 0;
    localparam int META_W = 10;
    localparam int WAYS   = 4;
    localparam int WAY_W  = $clog2(WAYS);
    localparam int SETS   = 32;
    localparam int TAG_W  = TAG_HI - TAG_LO + 1;
    localparam int IDX_W  = IDX_HI - IDX_LO + 1;
    localparam logic [1:0] LRU_MRU = 2'b11;
    typedef enum logic [2:0] {IDLE, META, FILL, UPDATE, DONE} state_e;
endpackage

// File: rtl/cache_victim_sel.sv
// cache_victim_sel: combinational victim way selection from one set's metadata word.
// Ports: meta_i   - {way0, way1, way2, way3}, each {valid, lru[1:0], tag[6:0]}
//        victim_o - one-hot victim, bit 3 = way0 ... bit 0 = way3
// Rule: lowest-numbered invalid way, otherwise lowest-numbered way holding the minimum LRU.
module cache_victim_sel
    import cache_pkg::*;
(
    input  logic [WAYS*META_W-1:0] meta_i,
    output logic [WAYS-1:0]        victim_o
);
    logic [WAY_W-1:0]           inv_way;
    logic [WAY_W-1:0]           lru_way;
    logic [1:0]                 min_lru;
    logic [1:0]                 lru;
    logic                       any_inv;
    logic [WAYS*TAG_W-1:0]      unused_tags;

    for (genvar g = 0; g < WAYS; g++) begin : g_tag
        assign unused_tags[g*TAG_W +: TAG_W] = meta_i[(WAYS-1-g)*META_W +: TAG_W];
    end

    // Invalid scan runs high-to-low so the lowest invalid way is the last one written;
    // the LRU scan uses a strict compare so ties keep the lower way.
    always_comb begin
        any_inv = 1'b0;
        inv_way = '0;
        lru_way = '0;
        min_lru = LRU_MRU;
        lru     = '0;
        for (int k = WAYS-1; k >= 0; k--) begin
            if (!meta_i[(WAYS-1-k)*META_W + META_W-1]) begin
                any_inv = 1'b1;
                inv_way = WAY_W'(k);
            end
        end
        for (int k = 0; k < WAYS; k++) begin
            lru = meta_i[(WAYS-1-k)*META_W + TAG_W +: 2];
            if (lru < min_lru) begin
                min_lru = lru;
                lru_way = WAY_W'(k);
            end
        end
        victim_o = {1'b1, {(WAYS-1){1'b0}}} >> (any_inv ? inv_way : lru_way);
    end
endmodule

// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl: miss-side controller; picks a victim, fetches an 8-word block, writes data and metadata.
// Ports: clk/rst_n (async active-low); miss_detected/miss_address from hit/miss logic;
//        meta_rd_data/meta_set_en/meta_write/meta_din to the metadata array;
//        data_write_way/data_word_en/data_we/data_out to the data array;
//        mem_req/mem_addr/mem_data/mem_data_valid to main memory; fsm_busy, fill_done status.
// Option: CACHE_FILL_CRIT_WORD_FIRST_EN starts the fill at the missed word and adds crit_word_valid.
module cache_fill_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int WORDS  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   miss_detected,
    input  logic [ADDR_W-1:0]      miss_address,
    input  logic [WAYS*META_W-1:0] meta_rd_data,
    input  logic [DATA_W-1:0]      mem_data,
    input  logic                   mem_data_valid,
    output logic [SETS-1:0]        meta_set_en,
    output logic [WAYS-1:0]        meta_write,
    output logic [META_W-1:0]      meta_din,
    output logic [WAYS-1:0]        data_write_way,
    output logic [WORDS-1:0]       data_word_en,
    output logic                   data_we,
    output logic [DATA_W-1:0]      data_out,
    output logic                   mem_req,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic                   fsm_busy,
    output logic                   fill_done
`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
    ,
    output logic                   crit_word_valid
`endif
);
    localparam int WB = $clog2(WORDS);

    state_e             state_q, state_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WB-1:0]      word_q, word_d;
    logic [WAYS-1:0]    victim_q, victim_d, victim_w;
    logic [WB-1:0]      issue_q, issue_d;
    logic [WB:0]        ret_q, ret_d;
    logic               mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic               data_we_q, data_we_d;
    logic [DATA_W-1:0]  data_out_q, data_out_d;
    logic [WORDS-1:0]   word_en_q, word_en_d;
    logic [WAYS-1:0]    wr_way_q, wr_way_d;
    logic [WAYS-1:0]    meta_we_q, meta_we_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               crit_q, crit_d;
    logic [WB-1:0]      base_word;
    logic [WB-1:0]      iss_word;
    logic [WB-1:0]      ret_word;
    logic               unused_addr;

`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
    assign base_word       = word_q;
    assign crit_word_valid = crit_q;
`else
    assign base_word       = '0;
`endif
    assign unused_addr = ^{miss_address[OFF_LO], word_q, crit_q};
    assign iss_word    = base_word + issue_q + 1'b1;
    assign ret_word    = base_word + ret_q[WB-1:0];

    cache_victim_sel u_victim (
        .meta_i   (meta_rd_data),
        .victim_o (victim_w)
    );

    // mem_req_q doubles as "fewer than WORDS issued": it is raised on entry to FILL and
    // dropped after the last request, so the 3-bit issue counter never has to reach WORDS.
    always_comb begin
        state_d    = state_q;
        tag_d      = tag_q;
        idx_d      = idx_q;
        word_d     = word_q;
        victim_d   = victim_q;
        issue_d    = issue_q;
        ret_d      = ret_q;
        mem_req_d  = 1'b0;
        mem_addr_d = '0;
        data_we_d  = 1'b0;
        data_out_d = '0;
        word_en_d  = '0;
        wr_way_d   = '0;
        meta_we_d  = '0;
        done_d     = 1'b0;
        crit_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (miss_detected) begin
                    state_d = META;
                    tag_d   = miss_address[TAG_HI:TAG_LO];
                    idx_d   = miss_address[IDX_HI:IDX_LO];
                    word_d  = miss_address[OFF_HI:OFF_LO+1];
                    issue_d = '0;
                    ret_d   = '0;
                end
            end
            META: begin
                state_d    = FILL;
                victim_d   = victim_w;
                mem_req_d  = 1'b1;
                mem_addr_d = {tag_q, idx_q, base_word, 1'b0};
            end
            FILL: begin
                if (mem_req_q) begin
                    issue_d    = issue_q + 1'b1;
                    mem_req_d  = issue_q != WB'(WORDS-1);
                    mem_addr_d = mem_req_d ? {tag_q, idx_q, iss_word, 1'b0} : '0;
                end
                if (mem_data_valid) begin
                    data_we_d  = 1'b1;
                    data_out_d = mem_data;
                    word_en_d  = WORDS'(1) << ret_word;
                    wr_way_d   = victim_q;
                    crit_d     = ret_q == '0;
                    ret_d      = ret_q + 1'b1;
                    if (ret_q == {1'b0, WB'(WORDS-1)}) begin
                        state_d   = UPDATE;
                        meta_we_d = victim_q;
                    end
                end
            end
            UPDATE: begin
                state_d = DONE;
                done_d  = 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tag_q      <= '0;
            idx_q      <= '0;
            word_q     <= '0;
            victim_q   <= '0;
            issue_q    <= '0;
            ret_q      <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            data_we_q  <= 1'b0;
            data_out_q <= '0;
            word_en_q  <= '0;
            wr_way_q   <= '0;
            meta_we_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            crit_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tag_q      <= tag_d;
            idx_q      <= idx_d;
            word_q     <= word_d;
            victim_q   <= victim_d;
            issue_q    <= issue_d;
            ret_q      <= ret_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            data_we_q  <= data_we_d;
            data_out_q <= data_out_d;
            word_en_q  <= word_en_d;
            wr_way_q   <= wr_way_d;
            meta_we_q  <= meta_we_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            crit_q     <= crit_d;
        end
    end

    assign meta_set_en    = (state_q == IDLE) ? '0 : SETS'(1) << idx_q;
    assign meta_din       = (state_q == UPDATE) ? {1'b1, LRU_MRU, tag_q} : '0;
    assign meta_write     = meta_we_q;
    assign data_write_way = wr_way_q;
    assign data_word_en   = word_en_q;
    assign data_we        = data_we_q;
    assign data_out       = data_out_q;
    assign mem_req        = mem_req_q;
    assign mem_addr       = mem_addr_q;
    assign fsm_busy       = busy_q;
    assign fill_done      = done_q;
endmodule

// File: tb/tb_cache_fill_ctrl.sv
// tb_cache_fill_ctrl: table-driven fills against an in-order variable-latency memory model.
module tb_cache_fill_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        miss_detected = 1'b0;
    logic [15:0] miss_address = '0;
    logic [39:0] meta_rd_data = '0;
    logic [15:0] mem_data = '0;
    logic        mem_data_valid = 1'b0;
    logic [31:0] meta_set_en;
    logic [3:0]  meta_write;
    logic [9:0]  meta_din;
    logic [3:0]  data_write_way;
    logic [7:0]  data_word_en;
    logic        data_we;
    logic [15:0] data_out;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        fsm_busy;
    logic        fill_done;
`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
    logic        crit_word_valid;
`endif

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [15:0] addr;
        logic [39:0] meta;
        logic [3:0]  exp_victim;
        logic [9:0]  exp_din;
        int          lat_min;
        int          lat_max;
    } vec_t;

    vec_t vecs[7];

    cache_fill_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .miss_detected  (miss_detected),
        .miss_address   (miss_address),
        .meta_rd_data   (meta_rd_data),
        .mem_data       (mem_data),
        .mem_data_valid (mem_data_valid),
        .meta_set_en    (meta_set_en),
        .meta_write     (meta_write),
        .meta_din       (meta_din),
        .data_write_way (data_write_way),
        .data_word_en   (data_word_en),
        .data_we        (data_we),
        .data_out       (data_out),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .fsm_busy       (fsm_busy),
        .fill_done      (fill_done)
`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
        ,
        .crit_word_valid(crit_word_valid)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] w(input logic v, input logic [1:0] lru, input logic [6:0] tag);
        return {v, lru, tag};
    endfunction

    // Runs one miss to completion (or until abort_after returns have been written).
    task automatic do_fill(input vec_t v, input int abort_after);
        logic [2:0]  base;
        logic [15:0] exp_a;
        logic [31:0] one;
        int          ready_q[$];
        logic [15:0] aq[$];
        int          issued, rets, lat, last_ready;
        bit          done, saw_meta;
        one = 32'd1;
        base = 3'd0;
`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
        base = v.addr[3:1];
`endif
        issued = 0; rets = 0; last_ready = 0; done = 0; saw_meta = 0;
        @(negedge clk);
        miss_address  = v.addr;
        meta_rd_data  = v.meta;
        miss_detected = 1'b1;
        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            @(negedge clk);
            if (cyc == 0) miss_address = ~v.addr;
            chk("fsm_busy_during_fill", fsm_busy, 1);
            if (mem_req) begin
                exp_a = {v.addr[15:4], 3'(base + 3'(issued)), 1'b0};
                chk("mem_addr", mem_addr, exp_a);
                issued++;
                lat = $urandom_range(v.lat_max, v.lat_min);
                last_ready = (cyc + lat > last_ready) ? cyc + lat : last_ready + 1;
                ready_q.push_back(last_ready);
                aq.push_back(mem_addr);
            end
            if (data_we) begin
                exp_a = {v.addr[15:4], 3'(base + 3'(rets)), 1'b0};
                chk("data_word_en", data_word_en, 8'd1 << 3'(base + 3'(rets)));
                chk("data_out", data_out, exp_a ^ 16'hA5A5);
                chk("data_write_way", data_write_way, v.exp_victim);
`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
                chk("crit_word_valid", crit_word_valid, rets == 0);
`endif
                rets++;
            end
            if (meta_write != 4'b0) begin
                saw_meta = 1;
                chk("meta_write", meta_write, v.exp_victim);
                chk("meta_din", meta_din, v.exp_din);
                chk("meta_set_en", meta_set_en, one << v.addr[8:4]);
                chk("returns_before_meta", rets, 8);
            end
            if (fill_done) begin
                done = 1;
                miss_detected = 1'b0;
            end
            if (abort_after > 0 && rets == abort_after) return;
            if (ready_q.size() > 0 && ready_q[0] <= cyc) begin
                mem_data_valid = 1'b1;
                mem_data = aq.pop_front() ^ 16'hA5A5;
                void'(ready_q.pop_front());
            end else begin
                mem_data_valid = 1'b0;
                mem_data = 16'($urandom);
            end
        end
        mem_data_valid = 1'b0;
        miss_detected  = 1'b0;
        chk("fill_done_seen", done, 1);
        chk("meta_written", saw_meta, 1);
        chk("requests_issued", issued, 8);
        chk("returns_written", rets, 8);
        @(negedge clk);
        chk("idle_after_fill", {fsm_busy, mem_req, data_we, fill_done}, 0);
    endtask

    initial begin
        vecs[0] = '{16'h3A46, 40'h0, 4'b1000, 10'h39D, 4, 4};
        vecs[1] = '{16'h3A46, {w(1,2'b11,7'h11), w(1,2'b01,7'h12), w(1,2'b00,7'h13), w(1,2'b10,7'h14)}, 4'b0010, 10'h39D, 2, 7};
        vecs[2] = '{16'h3A46, {w(1,2'b11,7'h21), w(1,2'b10,7'h22), w(1,2'b01,7'h23), w(1,2'b01,7'h24)}, 4'b0010, 10'h39D, 2, 7};
        vecs[3] = '{16'hFFFE, {w(1,2'b00,7'h31), w(0,2'b11,7'h32), w(1,2'b00,7'h33), w(0,2'b00,7'h34)}, 4'b0100, 10'h3FF, 1, 3};
        vecs[4] = '{16'h0000, {w(1,2'b10,7'h41), w(1,2'b00,7'h42), w(1,2'b00,7'h43), w(1,2'b11,7'h44)}, 4'b0100, 10'h380, 3, 5};
        vecs[5] = '{16'h3A4A, {w(1,2'b10,7'h51), w(1,2'b11,7'h52), w(1,2'b10,7'h53), w(1,2'b01,7'h54)}, 4'b0001, 10'h39D, 2, 7};
        vecs[6] = '{16'h1234, {w(1,2'b00,7'h61), w(1,2'b01,7'h62), w(1,2'b10,7'h63), w(0,2'b11,7'h64)}, 4'b0001, 10'h389, 1, 1};
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {mem_req, data_we, fsm_busy, fill_done, meta_write, data_write_way, data_word_en, meta_din}, 0);
        chk("reset_bus", {mem_addr, data_out, meta_set_en}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_set_en", meta_set_en, 0);
        for (int i = 0; i < 7; i++) do_fill(vecs[i], 0);
        do_fill(vecs[0], 3);
        rst_n = 1'b0;
        miss_detected = 1'b0;
        mem_data_valid = 1'b0;
        #1;
        chk("abort_ctrl", {mem_req, data_we, fsm_busy, fill_done, meta_write, data_write_way, data_word_en, meta_din}, 0);
        chk("abort_bus", {mem_addr, data_out, meta_set_en}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_data_valid = 1'b1;
        mem_data = 16'hBEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("late_response_dropped", {data_we, fsm_busy, data_word_en}, 0);
        end
        mem_data_valid = 1'b0;
        do_fill(vecs[1], 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
